// File: rtl/param_sync_up_down_counter.sv
// Parametrised synchronous up/down counter with enable, parallel load,
// programmable modulus, wrap/saturate mode, terminal count and wrap pulse.
// Q/qbar port names are kept so it drops in for the old 3-bit counter.
module param_sync_up_down_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             M,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sat,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    // Reject impossible moduli at elaboration time.
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_param_check
        $fatal(1, "param_sync_up_down_counter: illegal WIDTH/MODULUS");
    end

    // Top of range kept one bit wider so MODULUS = 2**WIDTH cannot alias.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   inc_ext;

    assign q_ext   = {1'b0, q_q};
    assign d_ext   = {1'b0, d};
    assign inc_ext = q_ext + (WIDTH + 1)'(1);

    // Next-count selection: load, then hold, then up/down with wrap or saturate.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = (d_ext > MAX_EXT) ? MAX_Q : d;
        end else if (en) begin
            if (!M) begin
                if (q_ext < MAX_EXT) begin
                    q_d = inc_ext[WIDTH-1:0];
                end else if (!sat) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (q_q != '0) begin
                    q_d = q_q - WIDTH'(1);
                end else if (!sat) begin
                    q_d    = MAX_Q;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign qbar = ~q_q;
    assign wrap = wrap_q;
    assign tc   = M ? (q_q == '0) : (q_ext == MAX_EXT);

endmodule

// File: tb/tb_param_sync_up_down_counter.sv
module tb_param_sync_up_down_counter;

    localparam int WA = 4;
    localparam int MA = 10;
    localparam int WB = 3;
    localparam int MB = 8;

    logic          clk = 1'b0;

    logic          a_clear, a_m, a_en, a_load, a_sat;
    logic [WA-1:0] a_d;
    logic [WA-1:0] a_q, a_qbar;
    logic          a_tc, a_wrap;

    logic          b_clear, b_m, b_en, b_load, b_sat;
    logic [WB-1:0] b_d;
    logic [WB-1:0] b_q, b_qbar;
    logic          b_tc, b_wrap;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int mq_a = 0, mw_a = 0;
    int mq_b = 0, mw_b = 0;

    always #5 clk = ~clk;

    param_sync_up_down_counter #(.WIDTH(WA), .MODULUS(MA)) u_dut_a (
        .clk(clk), .clear(a_clear), .M(a_m), .en(a_en), .load(a_load),
        .d(a_d), .sat(a_sat), .Q(a_q), .qbar(a_qbar), .tc(a_tc), .wrap(a_wrap)
    );

    param_sync_up_down_counter #(.WIDTH(WB), .MODULUS(MB)) u_dut_b (
        .clk(clk), .clear(b_clear), .M(b_m), .en(b_en), .load(b_load),
        .d(b_d), .sat(b_sat), .Q(b_q), .qbar(b_qbar), .tc(b_tc), .wrap(b_wrap)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference step: compute the target count, then decide what happens if
    // it falls outside 0..mod-1.
    function automatic void model_step(input int q, input int ld, input int dv,
                                       input int e, input int m, input int s,
                                       input int md, output int nq, output int nw);
        int target;
        nw = 0;
        if (ld != 0) begin
            nq = (dv > md - 1) ? md - 1 : dv;
        end else if (e == 0) begin
            nq = q;
        end else begin
            target = (m != 0) ? q - 1 : q + 1;
            if (target >= 0 && target < md) nq = target;
            else if (s != 0)                nq = q;
            else begin
                nq = (target + md) % md;
                nw = 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        int tca, tcb;
        tca = (a_m == 1'b1) ? (mq_a == 0) : (mq_a == MA - 1);
        tcb = (b_m == 1'b1) ? (mq_b == 0) : (mq_b == MB - 1);
        chk({tag, ".a_q"},    int'(a_q),    mq_a);
        chk({tag, ".a_qbar"}, int'(a_qbar), (~mq_a) & ((1 << WA) - 1));
        chk({tag, ".a_tc"},   int'(a_tc),   tca);
        chk({tag, ".a_wrap"}, int'(a_wrap), mw_a);
        chk({tag, ".b_q"},    int'(b_q),    mq_b);
        chk({tag, ".b_qbar"}, int'(b_qbar), (~mq_b) & ((1 << WB) - 1));
        chk({tag, ".b_tc"},   int'(b_tc),   tcb);
        chk({tag, ".b_wrap"}, int'(b_wrap), mw_b);
    endtask

    task automatic tick(input string tag);
        int nq, nw;
        @(posedge clk);
        #1;
        if (a_clear == 1'b0) begin mq_a = 0; mw_a = 0; end
        else begin
            model_step(mq_a, a_load, a_d, a_en, a_m, a_sat, MA, nq, nw);
            mq_a = nq; mw_a = nw;
        end
        if (b_clear == 1'b0) begin mq_b = 0; mw_b = 0; end
        else begin
            model_step(mq_b, b_load, b_d, b_en, b_m, b_sat, MB, nq, nw);
            mq_b = nq; mw_b = nw;
        end
        check_all(tag);
    endtask

    initial begin
        a_clear = 1'b0; a_m = 1'b0; a_en = 1'b1; a_load = 1'b0; a_sat = 1'b0; a_d = '0;
        b_clear = 1'b0; b_m = 1'b0; b_en = 1'b0; b_load = 1'b0; b_sat = 1'b0; b_d = '0;
        #3;
        check_all("reset");
        chk("reset.a_qbar_f", int'(a_qbar), 15);
        @(negedge clk);
        a_clear = 1'b1; b_clear = 1'b1;

        // count up with wrap
        for (int i = 0; i < 12; i++) tick("up");
        chk("up12.q", int'(a_q), 2);

        // down and saturate
        a_load = 1'b1; a_d = 4'd2; tick("ld2");
        a_load = 1'b0; a_m = 1'b1; a_sat = 1'b1; a_en = 1'b1;
        for (int i = 0; i < 4; i++) tick("dnsat");
        chk("dnsat.q", int'(a_q), 0);

        // load priority and clamp
        a_m = 1'b0; a_sat = 1'b0;
        a_load = 1'b1; a_d = 4'd9; tick("ld9");
        a_d = 4'd15; tick("clamp");
        chk("clamp.q", int'(a_q), 9);
        chk("clamp.wrap", int'(a_wrap), 0);
        a_d = 4'd3; a_en = 1'b0; tick("ld3");
        chk("ld3.q", int'(a_q), 3);

        // direction change and enable
        a_d = 4'd5; tick("ld5");
        a_load = 1'b0; a_en = 1'b1; a_m = 1'b0;
        for (int i = 0; i < 2; i++) tick("dir_up");
        a_m = 1'b1;
        for (int i = 0; i < 3; i++) tick("dir_dn");
        a_en = 1'b0;
        for (int i = 0; i < 2; i++) tick("dir_hold");
        chk("dir.q", int'(a_q), 4);

        // async clear mid-cycle
        a_load = 1'b1; a_d = 4'd7; tick("ld7");
        a_load = 1'b0;
        #2; a_clear = 1'b0; mq_a = 0; mw_a = 0;
        #1; check_all("aclr");
        chk("aclr.qbar", int'(a_qbar), 15);
        #1; a_clear = 1'b1;

        // async clear kills a pending wrap pulse
        a_load = 1'b1; a_d = 4'd9; tick("ld9b");
        a_load = 1'b0; a_en = 1'b1; a_m = 1'b0; a_sat = 1'b0; tick("wrapgen");
        chk("wrapgen.wrap", int'(a_wrap), 1);
        #2; a_clear = 1'b0; mq_a = 0; mw_a = 0;
        #1; check_all("aclr_wrap");
        #1; a_clear = 1'b1;

        // full-range modulus on the 3-bit instance
        b_m = 1'b1; b_sat = 1'b0; b_en = 1'b1;
        #1; chk("full.tc0", int'(b_tc), 1);
        tick("full_wrap");
        chk("full.q7", int'(b_q), 7);
        chk("full.wrap", int'(b_wrap), 1);
        for (int i = 0; i < 7; i++) tick("full_dn");
        chk("full.q0", int'(b_q), 0);

        // randomized phase on both instances
        for (int i = 0; i < 600; i++) begin
            a_clear = ($urandom_range(0, 49) != 0);
            a_m = 1'($urandom); a_en = ($urandom_range(0, 3) != 0);
            a_load = ($urandom_range(0, 7) == 0); a_sat = 1'($urandom);
            a_d = 4'($urandom);
            b_clear = ($urandom_range(0, 49) != 0);
            b_m = 1'($urandom); b_en = ($urandom_range(0, 3) != 0);
            b_load = ($urandom_range(0, 7) == 0); b_sat = ($urandom_range(0, 3) == 0);
            b_d = 3'($urandom);
            if (a_clear == 1'b0) begin mq_a = 0; mw_a = 0; end
            if (b_clear == 1'b0) begin mq_b = 0; mw_b = 0; end
            #1; check_all("rnd_comb");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
